// File: rtl/uart_prog_pkg.sv
// Shared types and defaults for the UART program loader (optional even parity: UART_PROG_PARITY_EN).
// No logic here: enums for the receive and loader state machines plus default baud divisor and terminator.
package uart_prog_pkg;

  localparam int          CLKS_PER_BIT_DEF = 434;
  localparam logic [31:0] END_WORD_DEF     = 32'h00000FFF;

`ifdef UART_PROG_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
`else
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
`endif

  typedef enum logic [1:0] {LD_IDLE, LD_RECV, LD_DONE} ld_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// UART byte receiver (8-N-1, or 8-E-1 with UART_PROG_PARITY_EN): 2-flop sync, mid-bit sampling, result pulse
// one cycle after the stop-bit sample. No backpressure: bytes are presented once and never held.
module uart_rx_core
  import uart_prog_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
`ifdef UART_PROG_PARITY_EN
  ,
  output logic       parity_err_o
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state_q, state_d;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;
  logic             half_hit, full_hit;
`ifdef UART_PROG_PARITY_EN
  logic             parity_q, par_bad_q;
`endif

  assign half_hit = (cnt_q == HALF_M1);
  assign full_hit = (cnt_q == FULL_M1);
  assign byte_o   = shreg_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RX_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (rx_prev_q && !rx_sync_q) state_d = RX_START;
      // A start bit that is high again at mid-bit was a glitch.
      RX_START: if (half_hit) state_d = rx_sync_q ? RX_IDLE : RX_DATA;
`ifdef UART_PROG_PARITY_EN
      RX_DATA:   if (full_hit && bit_idx_q == 3'd7) state_d = RX_PARITY;
      RX_PARITY: if (full_hit) state_d = RX_STOP;
`else
      RX_DATA:  if (full_hit && bit_idx_q == 3'd7) state_d = RX_STOP;
`endif
      RX_STOP:  if (full_hit) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
`ifdef UART_PROG_PARITY_EN
      parity_q     <= 1'b0;
      par_bad_q    <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx_i;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
`ifdef UART_PROG_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      cnt_q <= (state_q == RX_IDLE || state_d != state_q || full_hit) ? '0 : cnt_q + CNT_W'(1);

      if (state_q == RX_START) begin
        bit_idx_q <= '0;
`ifdef UART_PROG_PARITY_EN
        parity_q  <= 1'b0;
`endif
      end
      if (state_q == RX_DATA && full_hit) begin
        shreg_q   <= {rx_sync_q, shreg_q[7:1]};
        bit_idx_q <= bit_idx_q + 3'd1;
`ifdef UART_PROG_PARITY_EN
        parity_q  <= parity_q ^ rx_sync_q;
`endif
      end
`ifdef UART_PROG_PARITY_EN
      // Even parity: data bits xor parity bit must be zero.
      if (state_q == RX_PARITY && full_hit) par_bad_q <= parity_q ^ rx_sync_q;
`endif
      if (state_q == RX_STOP && full_hit) begin
        if (!rx_sync_q) frame_err_o <= 1'b1;
`ifdef UART_PROG_PARITY_EN
        else if (par_bad_q) parity_err_o <= 1'b1;
`endif
        else byte_valid_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: little-endian word assembly into sequential memory writes; we_o two cycles after
// the stop-bit sample. No backpressure: memory must take every strobe (optional parity: UART_PROG_PARITY_EN).
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter int          CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int          WORD_BYTES   = 4,
  parameter int          ADDR_W       = 10,
  parameter logic [31:0] END_WORD     = END_WORD_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  rx_i,
  output logic                  prog_ready_o,
  output logic                  we_o,
  output logic [ADDR_W-1:0]     addr_o,
  output logic [8*WORD_BYTES-1:0] wdata_o,
  output logic                  done_o,
  output logic                  frame_err_o,
  output logic                  overflow_o,
  output logic [ADDR_W:0]       word_cnt_o
`ifdef UART_PROG_PARITY_EN
  ,
  output logic                  parity_err_o
`endif
);

  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int BIDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [DATA_W-1:0] END_W = DATA_W'(END_WORD);

  ld_state_e          ld_state_q, ld_state_d;
  logic [7:0]         byte_dat;
  logic               byte_vld, frame_err_pls;
  logic               en_q, en_rise, accept, last_byte, is_term, addr_full;
  logic [BIDX_W-1:0]  byte_idx_q;
  logic [DATA_W-1:0]  word_q, word_next;
  logic [ADDR_W-1:0]  addr_q;
`ifdef UART_PROG_PARITY_EN
  logic               parity_err_pls;
`endif

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .byte_o      (byte_dat),
    .byte_valid_o(byte_vld),
    .frame_err_o (frame_err_pls)
`ifdef UART_PROG_PARITY_EN
    ,
    .parity_err_o(parity_err_pls)
`endif
  );

  assign en_rise      = en_i && !en_q;
  assign accept       = byte_vld && (ld_state_q == LD_RECV) && en_i;
  assign last_byte    = (byte_idx_q == BIDX_W'(WORD_BYTES - 1));
  assign is_term      = accept && last_byte && (word_next == END_W);
  // The word counter's top bit means every address has already been written.
  assign addr_full    = word_cnt_o[ADDR_W];
  assign prog_ready_o = (ld_state_q == LD_RECV);
  assign done_o       = (ld_state_q == LD_DONE);

  always_comb begin
    word_next = word_q;
    word_next[8*byte_idx_q +: 8] = byte_dat;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ld_state_q <= LD_IDLE;
    else         ld_state_q <= ld_state_d;
  end

  always_comb begin
    ld_state_d = ld_state_q;
    case (ld_state_q)
      LD_IDLE: if (en_i) ld_state_d = LD_RECV;
      LD_RECV: begin
        if (!en_i)        ld_state_d = LD_IDLE;
        else if (is_term) ld_state_d = LD_DONE;
      end
      LD_DONE: if (!en_i) ld_state_d = LD_IDLE;
      default: ld_state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q        <= 1'b0;
      we_o        <= 1'b0;
      addr_o      <= '0;
      wdata_o     <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      word_cnt_o  <= '0;
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
`ifdef UART_PROG_PARITY_EN
      parity_err_o <= 1'b0;
`endif
    end else begin
      en_q <= en_i;
      we_o <= 1'b0;

      // Count and sticky flags survive an abort and are cleared only by a fresh enable.
      if (en_rise) begin
        word_cnt_o  <= '0;
        frame_err_o <= 1'b0;
        overflow_o  <= 1'b0;
`ifdef UART_PROG_PARITY_EN
        parity_err_o <= 1'b0;
`endif
      end

      if (ld_state_q != LD_RECV || !en_i) begin
        byte_idx_q <= '0;
        word_q     <= '0;
        addr_q     <= '0;
      end else if (accept) begin
        if (last_byte) begin
          byte_idx_q <= '0;
          word_q     <= '0;
          if (!is_term) begin
            if (addr_full) begin
              overflow_o <= 1'b1;
            end else begin
              we_o       <= 1'b1;
              addr_o     <= addr_q;
              wdata_o    <= word_next;
              addr_q     <= addr_q + ADDR_W'(1);
              word_cnt_o <= word_cnt_o + (ADDR_W+1)'(1);
            end
          end
        end else begin
          byte_idx_q <= byte_idx_q + BIDX_W'(1);
          word_q     <= word_next;
        end
      end

      if (frame_err_pls) frame_err_o <= 1'b1;
`ifdef UART_PROG_PARITY_EN
      if (parity_err_pls) parity_err_o <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader (CLKS_PER_BIT=8, ADDR_W=2): expected writes go to a queue, a monitor
// pops and compares on every we_o; status flags are compared directly after each scenario.
module tb_uart_prog_loader;

  localparam int CPB = 8;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          rx = 1'b1;
  logic          prog_ready, we, done, frame_err, overflow;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [AW:0]   word_cnt;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .WORD_BYTES  (4),
    .ADDR_W      (AW),
    .END_WORD    (32'h00000FFF)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .rx_i        (rx),
    .prog_ready_o(prog_ready),
    .we_o        (we),
    .addr_o      (addr),
    .wdata_o     (wdata),
    .done_o      (done),
    .frame_err_o (frame_err),
    .overflow_o  (overflow),
    .word_cnt_o  (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", addr, wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(addr), 32'(e.addr));
        check("wr_data", wdata, e.data);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    rx = 1'b1;
    idle(3);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset state.
    #2 rst_n = 1'b0;
    idle(3);
    check("rst_prog_ready", 32'(prog_ready), 0);
    check("rst_we", 32'(we), 0);
    check("rst_done", 32'(done), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_word_cnt", 32'(word_cnt), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_wdata", wdata, 0);
    rst_n = 1'b1;
    idle(3);

    // Single word.
    en = 1'b1;
    idle(3);
    check("ready_after_en", 32'(prog_ready), 1);
    expect_wr(2'd0, 32'h00000513);
    send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    idle(4);
    check("cnt_one_word", 32'(word_cnt), 1);
    en = 1'b0;
    idle(3);
    check("ready_en_low", 32'(prog_ready), 0);
    check("cnt_holds_en_low", 32'(word_cnt), 1);

    // Three words then terminator; a word after the terminator is ignored.
    en = 1'b1;
    idle(3);
    expect_wr(2'd0, 32'h11111111);
    expect_wr(2'd1, 32'h22222222);
    expect_wr(2'd2, 32'hA5A5_0FFF);
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'hA5A5_0FFF);
    send_byte(8'hFF, 1'b1); send_byte(8'h0F, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    idle(4);
    check("term_done", 32'(done), 1);
    check("term_ready", 32'(prog_ready), 0);
    check("term_cnt", 32'(word_cnt), 3);
    send_word(32'h12345678);
    idle(4);
    check("done_sticky", 32'(done), 1);
    en = 1'b0;
    idle(3);
    check("done_clear", 32'(done), 0);

    // Framing error, then a good word.
    en = 1'b1;
    idle(3);
    check("cnt_clear_on_rise", 32'(word_cnt), 0);
    send_byte(8'h55, 1'b0);
    idle(4);
    check("frame_err_set", 32'(frame_err), 1);
    expect_wr(2'd0, 32'hDEADBEEF);
    send_word(32'hDEADBEEF);
    idle(4);
    check("cnt_after_ferr", 32'(word_cnt), 1);
    check("frame_err_sticky", 32'(frame_err), 1);
    en = 1'b0;
    idle(3);
    en = 1'b1;
    idle(3);
    check("frame_err_clear", 32'(frame_err), 0);

    // Address space exhaustion with 4-word memory.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_wr(AW'(i), 32'h1000_0000 + 32'(i));
      send_word(32'h1000_0000 + 32'(i));
    end
    idle(4);
    check("overflow_set", 32'(overflow), 1);
    check("overflow_cnt", 32'(word_cnt), 4);
    check("overflow_ready", 32'(prog_ready), 1);
    en = 1'b0;
    idle(3);
    en = 1'b1;
    idle(3);
    check("overflow_clear", 32'(overflow), 0);

    // Abort after two bytes discards the partial word.
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
    en = 1'b0;
    idle(3);
    en = 1'b1;
    idle(3);
    expect_wr(2'd0, 32'h44332211);
    send_word(32'h44332211);
    idle(4);
    check("abort_cnt", 32'(word_cnt), 1);

    // Single-cycle glitch on rx must not create a byte.
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    idle(20);
    expect_wr(2'd1, 32'h88776655);
    send_word(32'h88776655);
    idle(4);
    check("glitch_cnt", 32'(word_cnt), 2);

    // Asynchronous reset in the middle of a frame with a partial word pending.
    send_byte(8'h99, 1'b1); send_byte(8'h98, 1'b1);
    @(negedge clk) rx = 1'b0;
    idle(3 * CPB);
    rx = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(prog_ready), 0);
    check("midrst_cnt", 32'(word_cnt), 0);
    check("midrst_we", 32'(we), 0);
    check("midrst_wdata", wdata, 0);
    idle(4);
    rst_n = 1'b1;
    idle(20);
    expect_wr(2'd0, 32'h0D0C0B0A);
    send_word(32'h0D0C0B0A);
    idle(20);
    check("pending_writes", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
